alu_serial_ctrl: RTL and testbench



---
 rtl/alu_serial_ctrl_if.sv | 33 +++
 rtl/alu_serial_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between the decode stage and alu_serial_ctrl.
//
// Handshake: a request is accepted on a rising clk edge where start_i=1 and
// ready_o=1; ctrl_i/src1_i/src2_i are sampled on that same edge and may change
// afterwards. start_i while ready_o=0 is dropped (never queued). done_o is a
// one-cycle pulse; result_o and the flags are valid from that cycle on and are
// held until the next completion. There is no back-pressure on the result.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;

  // Requester side (decode/control stage, or the testbench).
  modport master (
    output start_i, ctrl_i, src1_i, src2_i,
    input  ready_o, done_o, result_o, zero_o, cout_o, overflow_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i,
    output ready_o, done_o, result_o, zero_o, cout_o, overflow_o
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit slice walks the operands LSB first,
// carry kept in a flop, result assembled in a right-shifting register.
// Optional feature macro: ALU_SERIAL_ABORT_EN adds the abort_i input, which
// drops an operation in RUN/FIX back to IDLE without a completion.
// Unsupported ctrl codes run the normal latency and complete with result 0,
// cout/overflow 0; zero_o still reflects result_o == 0.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef ALU_SERIAL_ABORT_EN
  input  logic               abort_i,
`endif
  alu_serial_ctrl_if.slave   bus,
  output logic [1:0]         o_dbg_state
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_ctrl;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sum_msb;
  logic             r_ovf_cap;
  logic             r_cout_cap;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_cout;
  logic             r_ovf;

  logic             w_abort;
  logic             w_last;
  logic             w_valid;
  logic             w_arith;
  logic             w_a;
  logic             w_b;
  logic             w_sum;
  logic             w_carry_out;
  logic             w_bit;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_slt_res;

`ifdef ALU_SERIAL_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // Per-bit slice: operands are consumed from bit 0 of the shifting copies.
  assign w_last      = (r_cnt == CW'(WIDTH - 1));
  assign w_arith     = r_ctrl[1];
  assign w_a         = r_a[0] ^ r_ctrl[3];
  assign w_b         = r_b[0] ^ r_ctrl[2];
  assign w_sum       = w_a ^ w_b ^ r_carry;
  assign w_carry_out = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);
  assign w_shift_next = {w_bit, r_shift[WIDTH-1:1]};
  // SLT: upper bits were written as 0 during RUN, bit 0 gets the corrected sign.
  assign w_slt_res   = {r_shift[WIDTH-1:1], r_sum_msb ^ r_ovf_cap};

  // Slice output mux; LESS keeps only bit 0 (later overwritten in FIX).
  always_comb begin
    w_bit = 1'b0;
    case (r_ctrl[1:0])
      2'b00:   w_bit = w_a & w_b;
      2'b01:   w_bit = w_a | w_b;
      2'b10:   w_bit = w_sum;
      default: w_bit = (r_cnt == '0) ? w_sum : 1'b0;
    endcase
  end

  // Decode of the ctrl codes that produce a real result.
  always_comb begin
    w_valid = 1'b0;
    case (r_ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: w_valid = 1'b1;
      default: w_valid = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic; abort outranks the end-of-run transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (bus.start_i) w_state_next = RUN;
      RUN: begin
        if (w_abort)     w_state_next = IDLE;
        else if (w_last) w_state_next = (r_ctrl[1:0] == 2'b11) ? FIX : DONE;
      end
      FIX:     w_state_next = w_abort ? IDLE : DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, bit walk, flag capture and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_sum_msb  <= 1'b0;
      r_ovf_cap  <= 1'b0;
      r_cout_cap <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.start_i) begin
            r_ctrl  <= bus.ctrl_i;
            r_a     <= bus.src1_i;
            r_b     <= bus.src2_i;
            r_shift <= '0;
            r_carry <= bus.ctrl_i[2];
          end
        end
        RUN: begin
          if (w_abort) begin
            r_cnt <= '0;
          end else begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_shift <= w_shift_next;
            r_carry <= w_carry_out;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
              r_sum_msb  <= w_sum;
              r_ovf_cap  <= r_carry ^ w_carry_out;
              r_cout_cap <= w_carry_out;
              if (r_ctrl[1:0] != 2'b11) begin
                r_result <= w_valid ? w_shift_next : '0;
                r_zero   <= w_valid ? (w_shift_next == '0) : 1'b1;
                r_cout   <= w_valid & w_arith & w_carry_out;
                r_ovf    <= w_valid & w_arith & (r_carry ^ w_carry_out);
              end
            end
          end
        end
        FIX: begin
          if (!w_abort) begin
            r_result <= w_valid ? w_slt_res : '0;
            r_zero   <= w_valid ? (w_slt_res == '0) : 1'b1;
            r_cout   <= w_valid & r_cout_cap;
            r_ovf    <= w_valid & r_ovf_cap;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.ready_o    = (r_state == IDLE);
  assign bus.done_o     = (r_state == DONE);
  assign bus.result_o   = r_result;
  assign bus.zero_o     = r_zero;
  assign bus.cout_o     = r_cout;
  assign bus.overflow_o = r_ovf;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=32): directed vector table,
// hand-written multi-cycle sequences and random ops against a reference model.
module tb_alu_serial_ctrl;
  localparam int W = 32;

  logic       clk;
  logic       rst_n;
  logic       abort_i;
  logic [1:0] dbg_state;

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ALU_SERIAL_ABORT_EN
    .abort_i     (abort_i),
`endif
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         co;
    logic         ov;
  } ref_t;

  function automatic ref_t ref_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    ref_t r;
    logic [W-1:0] aa, bb;
    logic [W:0]   s;
    aa = c[3] ? ~a : a;
    bb = c[2] ? ~b : b;
    s  = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c[2]};
    r  = '0;
    if (c == 4'b0000 || c == 4'b0001 || c == 4'b0010 || c == 4'b0110 ||
        c == 4'b0111 || c == 4'b1100) begin
      case (c[1:0])
        2'b00: r.res = aa & bb;
        2'b01: r.res = aa | bb;
        2'b10: r.res = s[W-1:0];
        default: r.res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      endcase
      if (c[1]) begin
        r.co = s[W];
        r.ov = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
      end
    end
    r.z = (r.res == '0);
    return r;
  endfunction

  // ---------------- driver ----------------
  // Issues one request, optionally pulses a stray start pulse_at cycles in,
  // and waits (bounded) for done_o. lat = edges after the accepting edge.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pulse_at, output ref_t got, output int lat);
    int waited;
    waited = 0;
    got    = '0;
    lat    = -1;
    while (!bus.ready_o && waited < 100) begin
      @(posedge clk); #1; waited++;
    end
    bus.start_i = 1'b1;
    bus.ctrl_i  = c;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.ctrl_i  = 4'($urandom_range(0, 15));
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.done_o) begin
        lat       = k;
        got.res   = bus.result_o;
        got.z     = bus.zero_o;
        got.co    = bus.cout_o;
        got.ov    = bus.overflow_o;
        break;
      end
      if (k == pulse_at) begin
        bus.start_i = 1'b1;
        bus.ctrl_i  = 4'b0110;
        bus.src1_i  = 32'hDEAD_BEEF;
        bus.src2_i  = 32'h1234_5678;
      end else if (k == pulse_at + 1) begin
        bus.start_i = 1'b0;
      end
    end
    if (lat < 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      check("done_single_pulse", {31'd0, bus.done_o}, 32'd0);
      check("ready_after_done", {31'd0, bus.ready_o}, 32'd1);
    end
  endtask

  task automatic check_result(input string name, input ref_t got, input ref_t exp);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check({name, "_result"}, got.res, e);
    check({name, "_zero"}, {31'd0, got.z}, {31'd0, exp.z});
    check({name, "_cout"}, {31'd0, got.co}, {31'd0, exp.co});
    check({name, "_ovf"},  {31'd0, got.ov}, {31'd0, exp.ov});
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         co;
    logic         ov;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    ref_t got, exp;
    int   lat, done_seen;
    logic [3:0] c;
    logic [W-1:0] a, b;
    logic [3:0] ops[6];
    logic [W-1:0] edge_vals[6];

    ops       = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    edge_vals = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'h8000_0001};

    //          ctrl     A              B              result         z     co    ov    lat
    vecs[0] = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32};
    vecs[1] = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32};
    vecs[2] = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 33};
    vecs[3] = '{4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 33};
    vecs[4] = '{4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32};
    vecs[5] = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 32};
    vecs[6] = '{4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32};
    vecs[7] = '{4'b0101, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32};
    vecs[8] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32};
    vecs[9] = '{4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32};

    rst_n       = 1'b0;
    abort_i     = 1'b0;
    bus.start_i = 1'b0;
    bus.ctrl_i  = 4'b0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", bus.result_o, 32'd0);
    check("rst_zero",   {31'd0, bus.zero_o}, 32'd1);
    check("rst_cout",   {31'd0, bus.cout_o}, 32'd0);
    check("rst_ovf",    {31'd0, bus.overflow_o}, 32'd0);
    check("rst_done",   {31'd0, bus.done_o}, 32'd0);
    check("rst_ready",  {31'd0, bus.ready_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].res);
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, -1, got, lat);
      exp = '{res: vecs[i].res, z: vecs[i].z, co: vecs[i].co, ov: vecs[i].ov};
      check_result($sformatf("vec%0d", i), got, exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Stray start while running must be dropped.
    exp_q.push_back(32'd3);
    run_op(4'b0010, 32'd1, 32'd2, 5, got, lat);
    check_result("start_in_run", got, '{res: 32'd3, z: 1'b0, co: 1'b0, ov: 1'b0});
    check("start_in_run_latency", 32'(lat), 32'd32);
    repeat (40) @(posedge clk);
    #1;
    check("start_in_run_no_second_op", {31'd0, bus.ready_o}, 32'd1);
    check("start_in_run_hold", bus.result_o, 32'd3);

    // Asynchronous reset in the middle of an operation.
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'b0010;
    bus.src1_i  = 32'h0000_1111;
    bus.src2_i  = 32'h0000_2222;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_result", bus.result_o, 32'd0);
    check("midrst_zero",   {31'd0, bus.zero_o}, 32'd1);
    check("midrst_cout",   {31'd0, bus.cout_o}, 32'd0);
    check("midrst_ovf",    {31'd0, bus.overflow_o}, 32'd0);
    check("midrst_done",   {31'd0, bus.done_o}, 32'd0);
    check("midrst_ready",  {31'd0, bus.ready_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done_o) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);

`ifdef ALU_SERIAL_ABORT_EN
    // Produce a known result, then abort a second op at bit 5.
    exp_q.push_back(32'h0000_0030);
    run_op(4'b0010, 32'h10, 32'h20, -1, got, lat);
    check_result("pre_abort", got, '{res: 32'h30, z: 1'b0, co: 1'b0, ov: 1'b0});
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'b0110;
    bus.src1_i  = 32'h0000_0001;
    bus.src2_i  = 32'h0000_0009;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_ready", {31'd0, bus.ready_o}, 32'd1);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done_o) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_result_kept", bus.result_o, 32'h30);
    exp_q.push_back(32'h0000_0008);
    run_op(4'b0110, 32'h0000_000A, 32'h0000_0002, -1, got, lat);
    check_result("post_abort", got, '{res: 32'h8, z: 1'b0, co: 1'b1, ov: 1'b0});
    check("post_abort_latency", 32'(lat), 32'd32);
`endif

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
      a = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : 32'($urandom);
      b = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : 32'($urandom);
      exp = ref_alu(c, a, b);
      exp_q.push_back(exp.res);
      run_op(c, a, b, -1, got, lat);
      check_result($sformatf("rnd%0d_c%04b", n, c), got, exp);
      check($sformatf("rnd%0d_latency", n), 32'(lat), (c[1:0] == 2'b11) ? 32'd33 : 32'd32);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit in case the sequence above stalls.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
